fp32_to_fixed: RTL

Pipelined converter from IEEE-754 binary32 to signed two's-complement fixed point. It decodes the fp32 format that fp32_add and the other fp32 units produce, for downstream integer/fixed-point consumers such as rasteriser coordinates and index math. Rounding is round-to-nearest-even, with saturation and NaN flagging. It has a fixed latency and no backpressure, matching the valid-only streaming style of the fp32 units.

---
 rtl/fp32_pkg.sv | 37 +++
 rtl/shift_right_sticky.sv | 45 ++++
 rtl/fp32_to_fixed.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the fp32 family of units (fp32_add, fp32_to_fixed,
// fixed_to_fp32, ...).
//   FP32_BIAS       exponent bias of IEEE-754 binary32
//   FP32_MANT_BITS  stored fraction bits (hidden bit not counted)
//   FP32_EXP_MAX    all-ones exponent field (inf / NaN)
//   fp_class_e      coarse operand class
//   fp32_classify   maps a raw binary32 word onto fp_class_e
// ---------------------------------------------------------------------------
package fp32_pkg;

   localparam int         FP32_BIAS      = 127;
   localparam int         FP32_MANT_BITS = 23;
   localparam logic [7:0] FP32_EXP_MAX   = 8'hFF;

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_DENORM,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_e;

   function automatic fp_class_e fp32_classify(input logic [31:0] a);
      fp_class_e c;
      if (a[30:23] == FP32_EXP_MAX) begin
         c = (a[22:0] != '0) ? FP_NAN : FP_INF;
      end else if (a[30:23] == 8'h00) begin
         c = (a[22:0] != '0) ? FP_DENORM : FP_ZERO;
      end else begin
         c = FP_NORMAL;
      end
      return c;
   endfunction

endpackage

// File: rtl/shift_right_sticky.sv
// ---------------------------------------------------------------------------
// shift_right_sticky
// Combinational logical right shifter that also reports the rounding bits
// lost in the shift.
//   data_in    value to shift (DATA_W bits)
//   shamt_in   shift amount; any value above DATA_W shifts everything out
//   data_out   data_in >> shamt_in
//   guard_out  last bit shifted out (bit shamt_in-1 of data_in), 0 when
//              shamt_in is 0 or larger than DATA_W
//   sticky_out OR of every shifted-out bit below the guard bit
// Shift amounts of DATA_W+1 and above therefore give data_out = 0,
// guard_out = 0 and sticky_out = OR(data_in).
// ---------------------------------------------------------------------------
module shift_right_sticky #(
   parameter int DATA_W  = 24,
   parameter int SHIFT_W = 5
) (
   input  logic [DATA_W-1:0]  data_in,
   input  logic [SHIFT_W-1:0] shamt_in,
   output logic [DATA_W-1:0]  data_out,
   output logic               guard_out,
   output logic               sticky_out
);

   localparam logic [DATA_W-1:0]  ONE      = DATA_W'(1);
   localparam logic [SHIFT_W-1:0] SH_ONE   = SHIFT_W'(1);
   localparam logic [SHIFT_W-1:0] DATA_W_S = SHIFT_W'(DATA_W);

   // mask selects the bits strictly below the guard position
   logic [DATA_W-1:0] mask;

   always_comb begin
      data_out  = data_in >> shamt_in;
      guard_out = 1'b0;
      mask      = '1;
      if (shamt_in == '0) begin
         mask = '0;
      end else if (shamt_in <= DATA_W_S) begin
         guard_out = |(data_in & (ONE << (shamt_in - SH_ONE)));
         mask      = (ONE << (shamt_in - SH_ONE)) - ONE;
      end
      sticky_out = |(data_in & mask);
   end

endmodule

// File: rtl/fp32_to_fixed.sv
// ---------------------------------------------------------------------------
// fp32_to_fixed
// Four-stage pipelined conversion of an IEEE-754 binary32 operand into a
// signed Q(WIDTH-FRAC_BITS).FRAC_BITS value, round-to-nearest-even, with
// saturation and NaN flagging.
//   clk_in        system clock, all state on rising edge
//   rst_in        asynchronous active-high reset, clears every stage
//   valid_in      a_in carries an operand this cycle
//   a_in          fp32 operand
//   valid_out     data_out / flags valid this cycle
//   data_out      signed fixed-point result
//   overflow_out  result saturated (finite out of range, or +/-inf)
//   nan_out       operand was NaN, data_out forced to 0
//
// Handshake: valid-only streaming, no backpressure. An operand is accepted on
// every rising edge where valid_in=1 and rst_in=0; its result is presented
// with valid_out=1 exactly four edges later. Outputs hold their last value
// while valid_out=0.
//
// Stages: S1 unpack -> S2 align -> S3 round -> S4 output register.
// ---------------------------------------------------------------------------
module fp32_to_fixed
   import fp32_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             valid_in,
   input  logic [31:0]      a_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   output logic             overflow_out,
   output logic             nan_out
);

   localparam int WIDE = WIDTH + 24;

   // Left-shift distance that places mant's LSB at the output's LSB weight:
   // exp - (bias + mantissa bits) + FRAC_BITS.
   localparam logic signed [9:0] SHIFT_OFS =
      10'(FRAC_BITS - FP32_BIAS - FP32_MANT_BITS);
   localparam logic signed [9:0] WIDTH_S   = 10'(WIDTH);
   localparam logic signed [9:0] RS_CLAMP  = 10'sd26;

   localparam logic [WIDTH:0]   MAX_POS = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH:0]   MAX_NEG = {2'b01, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // ---------------- S1: unpack ----------------
   logic                s1_valid;
   logic                s1_sign;
   fp_class_e           s1_class;
   logic [23:0]         s1_mant;
   logic signed [9:0]   s1_shift;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_class <= FP_ZERO;
         s1_mant  <= '0;
         s1_shift <= '0;
      end else begin
         s1_valid <= valid_in;
         s1_sign  <= a_in[31];
         s1_class <= fp32_classify(a_in);
         s1_mant  <= {a_in[30:23] != 8'h00, a_in[22:0]};
         s1_shift <= $signed({2'b00, a_in[30:23]}) + SHIFT_OFS;
      end
   end

   // ---------------- S2: align ----------------
   logic signed [9:0] neg_shift;
   logic [4:0]        rs_amt;
   logic [23:0]       rs_data;
   logic              rs_guard;
   logic              rs_sticky;
   logic [WIDE-1:0]   wide;
   logic              too_far;
   logic [WIDTH:0]    s2_mag_d;
   logic              s2_pre_ovf_d;
   logic              s2_guard_d;
   logic              s2_sticky_d;

   always_comb begin
      neg_shift = -s1_shift;
      rs_amt    = '0;
      if (s1_shift < 0) begin
         rs_amt = (neg_shift > RS_CLAMP) ? 5'd26 : neg_shift[4:0];
      end
   end

   shift_right_sticky #(
      .DATA_W  (24),
      .SHIFT_W (5)
   ) u_rshift (
      .data_in    (s1_mant),
      .shamt_in   (rs_amt),
      .data_out   (rs_data),
      .guard_out  (rs_guard),
      .sticky_out (rs_sticky)
   );

   // Both shift directions land in a field WIDE bits wide so that anything
   // at or above bit WIDTH can be detected as a pre-rounding overflow. A
   // left shift of WIDTH or more pushes any nonzero mantissa out of range.
   always_comb begin
      wide        = '0;
      too_far     = 1'b0;
      s2_guard_d  = 1'b0;
      s2_sticky_d = 1'b0;
      if (s1_shift < 0) begin
         wide        = {{WIDTH{1'b0}}, rs_data};
         s2_guard_d  = rs_guard;
         s2_sticky_d = rs_sticky;
      end else if (s1_shift >= WIDTH_S) begin
         too_far = |s1_mant;
      end else begin
         wide = {{WIDTH{1'b0}}, s1_mant} << s1_shift[5:0];
      end
      s2_pre_ovf_d = too_far | (|wide[WIDE-1:WIDTH]);
      s2_mag_d     = wide[WIDTH:0];
   end

   logic           s2_valid;
   logic           s2_sign;
   logic           s2_nan;
   logic           s2_inf;
   logic [WIDTH:0] s2_mag;
   logic           s2_pre_ovf;
   logic           s2_guard;
   logic           s2_sticky;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_nan     <= 1'b0;
         s2_inf     <= 1'b0;
         s2_mag     <= '0;
         s2_pre_ovf <= 1'b0;
         s2_guard   <= 1'b0;
         s2_sticky  <= 1'b0;
      end else begin
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_nan     <= (s1_class == FP_NAN);
         s2_inf     <= (s1_class == FP_INF);
         s2_mag     <= s2_mag_d;
         s2_pre_ovf <= s2_pre_ovf_d;
         s2_guard   <= s2_guard_d;
         s2_sticky  <= s2_sticky_d;
      end
   end

   // ---------------- S3: round to nearest even ----------------
   logic           round_up;
   logic [WIDTH:0] mag_r_d;
   logic           ovf_d;

   always_comb begin
      round_up = s2_guard & (s2_sticky | s2_mag[0]);
      mag_r_d  = s2_mag + {{WIDTH{1'b0}}, round_up};
      // Negative range reaches one step further than positive.
      ovf_d    = s2_pre_ovf |
                 (!s2_sign && (mag_r_d > MAX_POS)) |
                 ( s2_sign && (mag_r_d > MAX_NEG));
   end

   logic           s3_valid;
   logic           s3_sign;
   logic           s3_nan;
   logic           s3_inf;
   logic           s3_ovf;
   logic [WIDTH:0] s3_mag;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s3_valid <= 1'b0;
         s3_sign  <= 1'b0;
         s3_nan   <= 1'b0;
         s3_inf   <= 1'b0;
         s3_ovf   <= 1'b0;
         s3_mag   <= '0;
      end else begin
         s3_valid <= s2_valid;
         s3_sign  <= s2_sign;
         s3_nan   <= s2_nan;
         s3_inf   <= s2_inf;
         s3_ovf   <= ovf_d;
         s3_mag   <= mag_r_d;
      end
   end

   // ---------------- S4: output ----------------
   logic [WIDTH-1:0] data_d;
   logic             overflow_d;
   logic             nan_d;

   // Negating a zero magnitude gives zero, so -0.0 and negative values that
   // round to zero come out as plain 0.
   always_comb begin
      data_d     = '0;
      overflow_d = 1'b0;
      nan_d      = 1'b0;
      if (s3_nan) begin
         nan_d = 1'b1;
      end else if (s3_inf || s3_ovf) begin
         data_d     = s3_sign ? SAT_NEG : SAT_POS;
         overflow_d = 1'b1;
      end else begin
         data_d = s3_sign ? (~s3_mag[WIDTH-1:0] + 1'b1) : s3_mag[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid_out    <= 1'b0;
         data_out     <= '0;
         overflow_out <= 1'b0;
         nan_out      <= 1'b0;
      end else begin
         valid_out <= s3_valid;
         if (s3_valid) begin
            data_out     <= data_d;
            overflow_out <= overflow_d;
            nan_out      <= nan_d;
         end
      end
   end

endmodule
